// File: rtl/mod13_pkg.sv
// mod13_pkg: constants and FSM encoding shared by the mod-13 counter, its monitor and benches.
package mod13_pkg;
  localparam int MOD_DEFAULT = 13;
  typedef enum logic [1:0] {SYNC = 2'd0, TRACK = 2'd1, FAULT = 2'd2} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of rolling over.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clock)
    if (reset || clr) count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/monitor_mod13.sv
// monitor_mod13: checks an upstream mod-MOD counter for legal steps and counts its wraps.
module monitor_mod13
  import mod13_pkg::*;
#(
  parameter int MOD    = MOD_DEFAULT,
  parameter int WRAP_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        counter,
  input  logic              resync,
  input  logic              clear,
  input  logic [WRAP_W-1:0] target,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              preset_req,
  output logic              error,
  output logic [1:0]        state
);
  localparam logic [3:0] LAST = 4'(MOD - 1);
  state_t st, st_n;
  logic [3:0] prev, prev_n;
  logic wrap_n, preset_n, error_n, inc, bad, is_wrap, legal;
  assign state = st;
  sat_counter #(.W(WRAP_W)) u_cnt (
    .clock(clock),
    .reset(reset),
    .clr  (clear),
    .inc  (inc),
    .count(wrap_count)
  );
  // A step to 0 from MOD-1 is a wrap; a step to 0 from anywhere else is an upstream reset.
  always_comb begin
    bad      = counter > LAST;
    is_wrap  = prev == LAST && counter == 4'd0;
    legal    = !bad && (counter == prev || counter == 4'd0 || (prev != LAST && counter == prev + 4'd1));
    st_n     = st;
    prev_n   = prev;
    error_n  = error;
    wrap_n   = 1'b0;
    preset_n = 1'b0;
    inc      = 1'b0;
    if (clear) begin
      st_n    = SYNC;
      error_n = 1'b0;
    end else if (resync) begin
      st_n = st == TRACK ? SYNC : st;
    end else if (st == SYNC) begin
      prev_n  = counter;
      st_n    = bad ? FAULT : TRACK;
      error_n = bad;
    end else if (st == TRACK) begin
      prev_n   = counter;
      st_n     = legal ? TRACK : FAULT;
      error_n  = !legal;
      inc      = legal && is_wrap;
      wrap_n   = inc;
      preset_n = inc && wrap_count != '1 && target != '0 && wrap_count + WRAP_W'(1) == target;
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      st         <= SYNC;
      prev       <= '0;
      wrap       <= 1'b0;
      preset_req <= 1'b0;
      error      <= 1'b0;
    end else begin
      st         <= st_n;
      prev       <= prev_n;
      wrap       <= wrap_n;
      preset_req <= preset_n;
      error      <= error_n;
    end
endmodule

// File: tb/tb_monitor_mod13.sv
// tb_monitor_mod13: directed vectors with a queue-based scoreboard for monitor_mod13.
module tb_monitor_mod13;
  logic clock = 1'b0;
  logic reset = 1'b0, resync = 1'b0, clear = 1'b0;
  logic [3:0] counter = 4'd0;
  logic [7:0] target = 8'd0;
  logic w8, pr8, e8, w2, pr2, e2;
  logic [7:0] wc8;
  logic [1:0] wc2, s8, s2;
  int checks = 0, errors = 0;

  typedef struct {
    string      name;
    bit         sel;
    logic       w;
    logic [7:0] wc;
    logic       pr;
    logic       err;
    logic [1:0] st;
  } exp_t;
  exp_t q[$];

  always #5 clock = ~clock;

  monitor_mod13 dut (
    .clock(clock), .reset(reset), .counter(counter), .resync(resync), .clear(clear),
    .target(target), .wrap(w8), .wrap_count(wc8), .preset_req(pr8), .error(e8), .state(s8)
  );
  monitor_mod13 #(.WRAP_W(2)) dut2 (
    .clock(clock), .reset(reset), .counter(counter), .resync(resync), .clear(clear),
    .target(target[1:0]), .wrap(w2), .wrap_count(wc2), .preset_req(pr2), .error(e2), .state(s2)
  );

  task automatic step(input string n, input logic [3:0] c, input logic rt, cl, rs, input bit sel,
                      input logic w, input logic [7:0] wc, input logic pr, err, input logic [1:0] st);
    exp_t e;
    @(negedge clock);
    counter = c;
    reset   = rt;
    clear   = cl;
    resync  = rs;
    e.name = n; e.sel = sel; e.w = w; e.wc = wc; e.pr = pr; e.err = err; e.st = st;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    logic a_w, a_pr, a_err;
    logic [7:0] a_wc;
    logic [1:0] a_st;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() != 0) begin
        e     = q.pop_front();
        a_w   = e.sel ? w2 : w8;
        a_wc  = e.sel ? {6'd0, wc2} : wc8;
        a_pr  = e.sel ? pr2 : pr8;
        a_err = e.sel ? e2 : e8;
        a_st  = e.sel ? s2 : s8;
        checks++;
        if ({a_w, a_wc, a_pr, a_err, a_st} !== {e.w, e.wc, e.pr, e.err, e.st}) begin
          errors++;
          $display("FAIL %s: got wrap=%0b wc=%0d pr=%0b err=%0b st=%0d, want wrap=%0b wc=%0d pr=%0b err=%0b st=%0d",
                   e.name, a_w, a_wc, a_pr, a_err, a_st, e.w, e.wc, e.pr, e.err, e.st);
        end
      end
    end
  end

  initial begin
    target = 8'd2;
    step("reset", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++)
      step("count", 4'(i % 13), 0, 0, 0, 0, i == 13 || i == 26, 8'(i < 13 ? 0 : (i < 26 ? 1 : 2)), i == 26, 0, 1);
    for (int v = 0; v < 6; v++) step("upstream_reset", 4'(v), 0, 0, 0, 0, 0, 2, 0, 0, 1);
    step("jump_fault", 9, 0, 0, 0, 0, 0, 2, 0, 1, 2);
    step("fault_hold", 10, 0, 0, 0, 0, 0, 2, 0, 1, 2);
    step("fault_hold", 11, 0, 0, 0, 0, 0, 2, 0, 1, 2);
    step("fault_hold", 12, 0, 0, 0, 0, 0, 2, 0, 1, 2);
    step("fault_nowrap", 0, 0, 0, 0, 0, 0, 2, 0, 1, 2);
    step("fault_resync", 3, 0, 0, 1, 0, 0, 2, 0, 1, 2);
    step("clear", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("post_clear_sync", 11, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("post_clear_12", 12, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("post_clear_wrap", 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    step("reset2", 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sync_bad", 14, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    step("reset_in_fault", 14, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t11", 11, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("t12", 12, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("twrap", 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    step("t1", 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step("t2", 2, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step("resync", 7, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    step("resync_accept", 7, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("hold7", 7, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step("inc8", 8, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step("zero_not_wrap", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step("clear_over_resync", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    target = 8'd3;
    step("w2_reset", 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    step("w2_sync12", 12, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    step("w2_wrap1", 0, 0, 0, 0, 1, 1, 1, 0, 0, 1);
    for (int k = 2; k <= 5; k++) begin
      for (int v = 1; v <= 12; v++) step("w2_count", 4'(v), 0, 0, 0, 1, 0, 8'(k - 1 > 3 ? 3 : k - 1), 0, 0, 1);
      step("w2_wrap", 0, 0, 0, 0, 1, 1, 8'(k > 3 ? 3 : k), k == 3, 0, 1);
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clock);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
